// File: rtl/pipelined_barrel_shifter_if.sv
// Request/response bundle for pipelined_barrel_shifter.
// out_zero exists only when SHIFTER_ZERO_FLAG_EN is defined.
interface pipelined_barrel_shifter_if #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_operand;
  logic [AMT_W-1:0] in_shift;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
`ifdef SHIFTER_ZERO_FLAG_EN
  logic             out_zero;

  modport master (
    output in_valid, in_operand, in_shift, in_op, out_ready,
    input  in_ready, out_valid, out_result, out_zero
  );
  modport slave (
    input  in_valid, in_operand, in_shift, in_op, out_ready,
    output in_ready, out_valid, out_result, out_zero
  );
`else
  modport master (
    output in_valid, in_operand, in_shift, in_op, out_ready,
    input  in_ready, out_valid, out_result
  );
  modport slave (
    input  in_valid, in_operand, in_shift, in_op, out_ready,
    output in_ready, out_valid, out_result
  );
`endif
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined multi-mode barrel shifter: one power-of-two mux level per registered stage.
// Optional SHIFTER_ZERO_FLAG_EN adds a registered out_zero flag alongside out_result.

// One mux level: shift/rotate by DIST when this stage's amount bit is set.
module pbs_stage #(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] d_i,
  input  logic             en_i,
  input  logic [2:0]       op_i,
  input  logic             sgn_i,
  output logic [WIDTH-1:0] d_o
);
  localparam logic [WIDTH-1:0] ONES    = '1;
  localparam logic [WIDTH-1:0] HI_MASK = ~(ONES >> DIST);

  always_comb begin
    d_o = d_i;
    if (en_i) begin
      case (op_i)
        3'd0:    d_o = d_i << DIST;
        3'd1:    d_o = d_i >> DIST;
        3'd2:    d_o = (d_i >> DIST) | (sgn_i ? HI_MASK : '0);
        3'd3:    d_o = (d_i << DIST) | (d_i >> (WIDTH - DIST));
        3'd4:    d_o = (d_i >> DIST) | (d_i << (WIDTH - DIST));
        default: d_o = d_i;
      endcase
    end
  end
endmodule

module pipelined_barrel_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int AMT_W   = 32
) (
  input  logic CLK,
  input  logic RST,
  pipelined_barrel_shifter_if.slave bus
);
  localparam int STAGES = SHAMT_W;
  localparam logic [2:0] OP_SLL = 3'd0;
  localparam logic [2:0] OP_SRL = 3'd1;
  localparam logic [2:0] OP_SRA = 3'd2;

  if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0 || AMT_W < SHAMT_W) begin : g_bad_cfg
    $error("pipelined_barrel_shifter: illegal WIDTH/AMT_W configuration");
  end

  logic                              advance;
  logic in_ovf;
  logic [STAGES:0]                   vld_pipe;
  logic [STAGES:0][WIDTH-1:0]        dat_pipe;
  logic [STAGES-1:0][2:0]            op_pipe;
  logic [STAGES-1:0][SHAMT_W-1:0]    amt_pipe;
  logic [STAGES-1:0]                 ovf_pipe;
  logic [STAGES-1:0]                 sgn_pipe;
  logic [STAGES-1:0][WIDTH-1:0]      shf;

  // Whole pipeline moves as one; a stalled output freezes every stage.
  assign advance      = !vld_pipe[STAGES] || bus.out_ready;
  assign bus.in_ready = advance;

  if (AMT_W > SHAMT_W) begin : g_ovf
    assign in_ovf = |bus.in_shift[AMT_W-1:SHAMT_W];
  end else begin : g_no_ovf
    assign in_ovf = 1'b0;
  end

  assign vld_pipe[0] = bus.in_valid && advance;
  assign dat_pipe[0] = bus.in_operand;
  assign op_pipe[0]  = bus.in_op;
  assign amt_pipe[0] = bus.in_shift[SHAMT_W-1:0];
  assign ovf_pipe[0] = in_ovf;
  assign sgn_pipe[0] = bus.in_operand[WIDTH-1];

`ifdef SHIFTER_ZERO_FLAG_EN
  logic zero_last;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    pbs_stage #(.WIDTH(WIDTH), .DIST(1 << k)) u_stage (
      .d_i   (dat_pipe[k]),
      .en_i  (amt_pipe[k][0]),
      .op_i  (op_pipe[k]),
      .sgn_i (sgn_pipe[k]),
      .d_o   (shf[k])
    );

    if (k < STAGES - 1) begin : g_mid
      logic               v_q;
      logic [WIDTH-1:0]   d_q;
      logic [2:0]         o_q;
      logic [SHAMT_W-1:0] a_q;
      logic               f_q;
      logic               s_q;

      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          v_q <= 1'b0;
          d_q <= '0;
          o_q <= '0;
          a_q <= '0;
          f_q <= 1'b0;
          s_q <= 1'b0;
        end else if (advance) begin
          v_q <= vld_pipe[k];
          d_q <= shf[k];
          o_q <= op_pipe[k];
          a_q <= amt_pipe[k] >> 1;  // next stage consumes bit 0
          f_q <= ovf_pipe[k];
          s_q <= sgn_pipe[k];
        end
      end

      assign vld_pipe[k+1] = v_q;
      assign dat_pipe[k+1] = d_q;
      assign op_pipe[k+1]  = o_q;
      assign amt_pipe[k+1] = a_q;
      assign ovf_pipe[k+1] = f_q;
      assign sgn_pipe[k+1] = s_q;
    end else begin : g_last
      logic [WIDTH-1:0] fin;
      logic             v_q;
      logic [WIDTH-1:0] d_q;

      // Out-of-range amounts saturate plain shifts; rotates stay modulo WIDTH.
      always_comb begin
        fin = shf[k];
        if (ovf_pipe[k]) begin
          case (op_pipe[k])
            OP_SLL, OP_SRL: fin = '0;
            OP_SRA:         fin = {WIDTH{sgn_pipe[k]}};
            default:        fin = shf[k];
          endcase
        end
      end

      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          v_q <= 1'b0;
          d_q <= '0;
        end else if (advance) begin
          v_q <= vld_pipe[k];
          d_q <= fin;
        end
      end

      assign vld_pipe[k+1] = v_q;
      assign dat_pipe[k+1] = d_q;

`ifdef SHIFTER_ZERO_FLAG_EN
      logic z_q;
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST)         z_q <= 1'b0;
        else if (advance) z_q <= (fin == '0);
      end
      assign zero_last = z_q;
`endif
    end
  end

  assign bus.out_valid  = vld_pipe[STAGES];
  assign bus.out_result = dat_pipe[STAGES];
`ifdef SHIFTER_ZERO_FLAG_EN
  assign bus.out_zero   = zero_last;
`endif
endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
Parametrised, pipelined, multi-mode barrel shifter for the datapath and ALU shift path. It supports logical left, logical right, arithmetic right, rotate left and rotate right. One log2(WIDTH) mux stage is registered per cycle. Valid/ready handshakes sit on both sides, so the block tolerates downstream backpressure without losing or reordering operations.

Parameters:
WIDTH, 32, operand/result width; must be a power of two, >= 4
SHAMT_W, $clog2(WIDTH) (5), effective shift-amount bits; also the pipeline depth
AMT_W, 32, width of the raw shift-amount input; must be >= SHAMT_W

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous, active-low reset
in_valid  input  1  request valid
in_ready  output  1  pipeline can accept a request this cycle
in_operand  input  WIDTH  value to shift
in_shift  input  AMT_W  shift amount, unsigned
in_op  input  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101-111 pass-through
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_result  output  WIDTH  shifted value
out_zero  output  1  only with SHIFTER_ZERO_FLAG_EN: out_result == 0

Behaviour:
- Interface: one clock CLK; reset RST is asynchronous, active-low.
- Reset (RST low, asynchronous): every stage valid bit = 0, out_valid = 0, out_result = 0, out_zero = 0, all stage data = 0.
  - in_ready = 1 once RST is high.
  - Reset mid-operation discards all in-flight requests; no result appears for them.
- Pipeline structure: stage k (k = 0..SHAMT_W-1) applies a shift/rotate of 2^k when amount bit k is set. Its output is registered.
  - Each stage register carries: data, valid, op, remaining amount bits, overflow flag, and the operand sign bit (captured at input).
- Latency: exactly SHAMT_W cycles from in_valid && in_ready to out_valid, absent stalls (5 for WIDTH=32).
- Throughput: one request per cycle.
- Handshake: advance = !out_valid || out_ready; in_ready = advance.
  - When advance is 1, every stage shifts forward together. Bubbles propagate as valid = 0.
  - When advance is 0, all stage registers hold and out_result/out_valid stay stable.
  - in_valid && !in_ready: the request is not taken; the source must hold it.
- Simultaneous out_ready and in_valid with a full pipeline: the result is consumed and the new request is accepted in the same cycle.
- Overflow: ovf = |in_shift[AMT_W-1:SHAMT_W], computed at capture and applied at the final stage:
  - SLL/SRL with ovf: result = 0.
  - SRA with ovf: result = {WIDTH{sign}}.
  - ROL/ROR: ovf ignored; only the low SHAMT_W bits are used (rotation is modulo WIDTH).
- Fill rules:
  - SLL fills 0 at the LSB end.
  - SRL fills 0 at the MSB end.
  - SRA fills the original operand sign bit at the MSB end.
  - Rotates wrap the bits.
- Pass-through ops (101-111) return the operand unchanged after the full latency.
- Shift amount 0 returns the operand unchanged for every op.
- Ordering: results leave in acceptance order; no combinational path from in_* to out_*.

Optional Feature:
SHIFTER_ZERO_FLAG_EN
- Defined: out_zero port exists. It is registered with out_result and equals (out_result == 0), including after overflow forcing. It holds during stalls and resets to 0.
- Undefined: out_zero port and its logic are absent; all other behaviour is identical.

Test Plan:
- SLL: operand 0x00000001, shift 31, after 5 cycles -> out_result 0x80000000, out_valid 1.
- SRA: 0x80000000 shift 4 -> 0xF8000000. SRL: same inputs -> 0x08000000.
- Rotates: ROR 0x000000F1 shift 4 -> 0x1000000F. ROL 0x80000001 shift 33 -> 0x00000003 (ovf ignored).
- Overflow: SLL 0xFFFFFFFF shift 0x20 -> 0x00000000. SRA 0x80000000 shift 0x40 -> 0xFFFFFFFF. SRA 0x7FFFFFFF shift 0x40 -> 0x00000000.
- Backpressure:
  - Issue 8 back-to-back SLL of 1 by shifts 0..7 with out_ready low for 3 cycles once out_valid rises.
  - Required: in_ready low during the stall, out_result held stable, outputs 0x01,0x02,...,0x80 in order, none lost or duplicated.
- Reset mid-flight: accept 3 requests, assert RST low for 1 cycle at cycle 2 -> out_valid 0 immediately, no stale results afterward. A new SRL 0x100 shift 8 -> 0x1 after 5 cycles.
- Zero flag (SHIFTER_ZERO_FLAG_EN defined): SRL 0x1 shift 1 -> out_zero 1. SRL 0x2 shift 1 -> out_zero 0.
